// File: rtl/hash_seq_pkg.sv
// Shared state type and sizing helpers for the hash block sequencer.
// Optional byte-count support is enabled with HASH_SEQ_BYTE_COUNT_EN.
package hash_seq_pkg;

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    WAIT,
    DIGEST
  } state_t;

  function automatic int words_per_block(
    input int block_w,
    input int bus_w
  );
    return block_w / bus_w;
  endfunction

  function automatic int bytes_per_word(input int bus_w);
    return bus_w / 8;
  endfunction

endpackage

// File: rtl/hash_block_sequencer_packer.sv
// Word-indexed block register with write-enable, clear and byte-mask.
// Masked-off bytes of a written word are stored as zero.
module hash_seq_packer
  import hash_seq_pkg::*;
#(
  parameter int BUS_WIDTH   = 64,
  parameter int BLOCK_WIDTH = 1024,
  parameter int IDX_W       = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [BUS_WIDTH-1:0]   wdata,
  input  logic [BUS_WIDTH/8-1:0] bmask,
  output logic [BLOCK_WIDTH-1:0] block
);

  localparam int BPW = bytes_per_word(BUS_WIDTH);

  logic [BUS_WIDTH-1:0] bits;

  always_comb begin
    bits = '0;
    for (int i = 0; i < BPW; i++)
      bits[i*8 +: 8] = {8{bmask[i]}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      block <= '0;
    else if (clr)
      block <= '0;
    else if (we)
      block[idx*BUS_WIDTH +: BUS_WIDTH] <= wdata & bits;
  end

endmodule

// File: rtl/hash_block_sequencer.sv
// Streams bus words into hash blocks and issues init/next/final commands.
// Define HASH_SEQ_BYTE_COUNT_EN to add din_nbytes for a partial last word.
module hash_block_sequencer
  import hash_seq_pkg::*;
#(
  parameter int BUS_WIDTH   = 64,
  parameter int BLOCK_WIDTH = 1024,
  parameter int LEN_WIDTH   = 128
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [BUS_WIDTH-1:0]   din,
  input  logic                   din_valid,
  input  logic                   din_last,
`ifdef HASH_SEQ_BYTE_COUNT_EN
  input  logic [$clog2(BUS_WIDTH/8+1)-1:0] din_nbytes,
`endif
  output logic                   din_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   len_err,
  output logic                   init,
  output logic                   next,
  output logic                   final_block,
  output logic [BLOCK_WIDTH-1:0] block,
  output logic [LEN_WIDTH-1:0]   data_length,
  input  logic                   hash_ready,
  input  logic                   digest_valid
);

  localparam int WPB   = words_per_block(BLOCK_WIDTH, BUS_WIDTH);
  localparam int BPW   = bytes_per_word(BUS_WIDTH);
  localparam int CNT_W = $clog2(WPB + 1);
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int LW1   = LEN_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  state_t               state;
  logic [CNT_W-1:0]     word_cnt;
  logic [LEN_WIDTH-1:0] len_acc;
  logic                 first_blk;
  logic                 is_final;
  logic                 hold;

  logic                 accept;
  logic                 clr;
  logic                 blk_full;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [BPW-1:0]       bmask;
  logic [LW1-1:0]       inc;
  logic [LW1-1:0]       len_sum;

  assign accept   = din_valid & din_ready;
  assign cnt_nxt  = word_cnt + 1'b1;
  assign blk_full = (cnt_nxt == CNT_W'(WPB));
  assign len_sum  = {1'b0, len_acc} + inc;

`ifdef HASH_SEQ_BYTE_COUNT_EN
  localparam int NB_W = $clog2(BPW + 1);

  // zero or out-of-range counts mean a full word
  always_comb begin
    bmask = '1;
    inc   = LW1'(BPW);
    if (din_last && din_nbytes != '0 && din_nbytes < NB_W'(BPW)) begin
      bmask = ~({BPW{1'b1}} << din_nbytes);
      inc   = LW1'(din_nbytes);
    end
  end
`else
  assign bmask = '1;
  assign inc   = LW1'(BPW);
`endif

  assign clr = (state == WAIT && !hold && hash_ready && !is_final) ||
               (state == DIGEST && digest_valid);

  hash_seq_packer #(
    .BUS_WIDTH  (BUS_WIDTH),
    .BLOCK_WIDTH(BLOCK_WIDTH),
    .IDX_W      (IDX_W)
  ) u_packer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .we     (accept),
    .idx    (word_cnt[IDX_W-1:0]),
    .wdata  (din),
    .bmask  (bmask),
    .block  (block)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FILL;
      word_cnt    <= '0;
      len_acc     <= '0;
      first_blk   <= 1'b1;
      is_final    <= 1'b0;
      hold        <= 1'b0;
      din_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      len_err     <= 1'b0;
      init        <= 1'b0;
      next        <= 1'b0;
      final_block <= 1'b0;
      data_length <= '0;
    end else begin
      init        <= 1'b0;
      next        <= 1'b0;
      final_block <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        FILL: begin
          din_ready <= 1'b1;
          if (accept) begin
            busy     <= 1'b1;
            word_cnt <= cnt_nxt;
            if (len_sum[LEN_WIDTH]) begin
              len_acc <= LEN_MAX;
              len_err <= 1'b1;
            end else begin
              len_acc <= len_sum[LEN_WIDTH-1:0];
            end
            if (blk_full || din_last) begin
              is_final  <= din_last;
              din_ready <= 1'b0;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (hash_ready) begin
            init        <= first_blk;
            next        <= !first_blk && !is_final;
            final_block <= is_final;
            data_length <= len_acc;
            first_blk   <= 1'b0;
            hold        <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // hash_ready may still reflect the idle core for one cycle
          if (hold) begin
            hold <= 1'b0;
          end else if (hash_ready) begin
            if (is_final) begin
              state <= DIGEST;
            end else begin
              word_cnt  <= '0;
              din_ready <= 1'b1;
              state     <= FILL;
            end
          end
        end
        DIGEST: begin
          if (digest_valid) begin
            done        <= 1'b1;
            busy        <= 1'b0;
            len_acc     <= '0;
            len_err     <= 1'b0;
            data_length <= '0;
            first_blk   <= 1'b1;
            is_final    <= 1'b0;
            word_cnt    <= '0;
            din_ready   <= 1'b1;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
